// File: rtl/noc_mem_responder.sv
// noc_mem_responder
//   Responder side of the remote data-memory path of a NoC node. Requests
//   reassembled by the packet collector are queued in a small FIFO and
//   executed one at a time on port 2 of the local RAM. Each request yields
//   exactly one response, returned in request order to the requesting node
//   with the same packet ID. Sub-word stores are done as read-modify-write.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake from the collector (ready = !full)
//   req_packet        {we, sz[1:0], addr, wdata}
//   req_src, req_id   requesting node and packet ID
//   ram_addr/wdata/we RAM port-2 address, write data, write strobe
//   ram_rdata         RAM port-2 read data, one cycle after the address
//   resp_valid/ready  response handshake towards the splitter
//   resp_packet       {status[1:0], rdata}; status 00 read, 01 write, 10 error
//   resp_dest, resp_id destination node and echoed packet ID
//
// State table
//   IDLE | wait for a queued request, pop and latch it
//   RD   | present the address to the RAM
//   CAP  | capture read data; finish a read or build the merged byte write
//   WR   | single-cycle RAM write
//   RESP | hold the response until the splitter accepts it

module noc_mem_responder #(
  parameter int NODE_COUNT      = 9,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int WORD            = 16,
  parameter int SIZE            = 256,
  parameter int QUEUE_DEPTH     = 8,
  localparam int NODE_W = $clog2(NODE_COUNT),
  localparam int ADDR_W = $clog2(SIZE),
  localparam int REQ_W  = 3 + ADDR_W + WORD,
  localparam int RSP_W  = 2 + WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [REQ_W-1:0]           req_packet,
  input  logic [NODE_W-1:0]          req_src,
  input  logic [PACKET_ID_WIDTH-1:0] req_id,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [WORD-1:0]            ram_wdata,
  output logic                       ram_we,
  input  logic [WORD-1:0]            ram_rdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [RSP_W-1:0]           resp_packet,
  output logic [NODE_W-1:0]          resp_dest,
  output logic [PACKET_ID_WIDTH-1:0] resp_id
);

  localparam int ENT_W = REQ_W + NODE_W + PACKET_ID_WIDTH;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_packet, req_src, req_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue fields
  logic [ENT_W-1:0]           head;
  logic [REQ_W-1:0]           head_pkt;
  logic [NODE_W-1:0]          head_src;
  logic [PACKET_ID_WIDTH-1:0] head_id;
  logic                       head_we;
  logic [1:0]                 head_sz;
  logic [ADDR_W-1:0]          head_addr;
  logic [WORD-1:0]            head_wdata;

  assign head       = fifo_mem[rd_ptr];
  assign head_pkt   = head[ENT_W-1 -: REQ_W];
  assign head_src   = head[PACKET_ID_WIDTH +: NODE_W];
  assign head_id    = head[PACKET_ID_WIDTH-1:0];
  assign head_we    = head_pkt[REQ_W-1];
  assign head_sz    = head_pkt[REQ_W-2 -: 2];
  assign head_addr  = head_pkt[WORD +: ADDR_W];
  assign head_wdata = head_pkt[WORD-1:0];

  // ----------------------------------------------------------------- FSM
  logic       w_we;
  logic [1:0] w_sz;
  logic [7:0] w_wbyte;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_sz == 2'b11)                 state_nxt = S_RESP;
          else if (head_we && head_sz == 2'b10) state_nxt = S_WR;
          else                                  state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_CAP;
      S_CAP:   state_nxt = w_we ? S_WR : S_RESP;
      S_WR:    state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ram_we     = (state == S_WR);
  assign resp_valid = (state == S_RESP);

  // Read lane select and byte merge, both from the word captured in CAP.
  // Byte lanes are the low two bytes of the word.
  logic [WORD-1:0] rd_sel, merged;

  always_comb begin
    rd_sel = ram_rdata;
    merged = ram_rdata;
    case (w_sz)
      2'b00: begin
        rd_sel       = {{(WORD-8){1'b0}}, ram_rdata[7:0]};
        merged[7:0]  = w_wbyte;
      end
      2'b01: begin
        rd_sel       = {{(WORD-8){1'b0}}, ram_rdata[15:8]};
        merged[15:8] = w_wbyte;
      end
      default: ;
    endcase
  end

  // Datapath registers. ram_addr/ram_wdata only change on the way into RD
  // or WR, so they hold their last value in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr    <= '0;
      ram_wdata   <= '0;
      resp_packet <= '0;
      resp_dest   <= '0;
      resp_id     <= '0;
      w_we        <= 1'b0;
      w_sz        <= '0;
      w_wbyte     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            w_we      <= head_we;
            w_sz      <= head_sz;
            w_wbyte   <= head_wdata[7:0];
            resp_dest <= head_src;
            resp_id   <= head_id;
            if (head_sz == 2'b11) begin
              resp_packet <= {2'b10, {WORD{1'b0}}};
            end else begin
              ram_addr <= head_addr;
              if (head_we && head_sz == 2'b10) ram_wdata <= head_wdata;
            end
          end
        end
        S_CAP: begin
          if (w_we) ram_wdata   <= merged;
          else      resp_packet <= {2'b00, rd_sel};
        end
        S_WR:    resp_packet <= {2'b01, {WORD{1'b0}}};
        default: ;
      endcase
    end
  end

endmodule
